// File: rtl/adc_ctrl_pkg.sv
// Shared types, config-word layout and OSR helpers for the SAR ADC conversion controller.
package adc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_H   = 3'd1,
    START_L   = 3'd2,
    WAIT_DONE = 3'd3,
    CAPTURE   = 3'd4
  } state_t;

  localparam int unsigned OSR_W  = 3;
  localparam int unsigned DLY_W  = 5;
  localparam int unsigned EDGE_W = 6;
  localparam int unsigned CFG_W  = 16;
  localparam int unsigned PCNT_W = 9;

  // OSR encodings: start pulses per oversampled result
  localparam logic [OSR_W-1:0] OSR_X1   = 3'd0;
  localparam logic [OSR_W-1:0] OSR_X4   = 3'd1;
  localparam logic [OSR_W-1:0] OSR_X16  = 3'd2;
  localparam logic [OSR_W-1:0] OSR_X64  = 3'd3;
  localparam logic [OSR_W-1:0] OSR_X256 = 3'd4;

  // config_1 = {delay_edge, 4'b0, osr, 3'b0}
  localparam int unsigned CFG1_OSR_LSB  = 3;
  localparam int unsigned CFG1_EDGE_LSB = 10;
  // config_2 = {1'b1, delay, delay, delay}
  localparam int unsigned CFG2_DLY0_LSB = 0;
  localparam int unsigned CFG2_DLY1_LSB = 5;
  localparam int unsigned CFG2_DLY2_LSB = 10;
  localparam int unsigned CFG2_MARK_BIT = 15;

  // Number of start pulses for an OSR code (1 << 2*osr)
  function automatic logic [PCNT_W-1:0] osr_pulses(input logic [OSR_W-1:0] osr);
    logic [PCNT_W-1:0] n;
    case (osr)
      OSR_X1:  n = PCNT_W'(1);
      OSR_X4:  n = PCNT_W'(4);
      OSR_X16: n = PCNT_W'(16);
      OSR_X64: n = PCNT_W'(64);
      default: n = PCNT_W'(256);
    endcase
    return n;
  endfunction

  // Launch is allowed only for osr<=4 and a one-hot delay
  function automatic logic cfg_ok(input logic [OSR_W-1:0] osr, input logic [DLY_W-1:0] dly);
    return (osr <= OSR_X256) && (dly != '0) && ((dly & (dly - DLY_W'(1))) == '0);
  endfunction

  function automatic logic [CFG_W-1:0] pack_cfg1(input logic [EDGE_W-1:0] dedge,
                                                 input logic [OSR_W-1:0]  osr);
    logic [CFG_W-1:0] c;
    c = '0;
    c[CFG1_EDGE_LSB +: EDGE_W] = dedge;
    c[CFG1_OSR_LSB +: OSR_W]   = osr;
    return c;
  endfunction

  function automatic logic [CFG_W-1:0] pack_cfg2(input logic [DLY_W-1:0] dly);
    logic [CFG_W-1:0] c;
    c = '0;
    c[CFG2_MARK_BIT]             = 1'b1;
    c[CFG2_DLY2_LSB +: DLY_W]    = dly;
    c[CFG2_DLY1_LSB +: DLY_W]    = dly;
    c[CFG2_DLY0_LSB +: DLY_W]    = dly;
    return c;
  endfunction

endpackage

// File: rtl/adc_ctrl_fifo.sv
// Synchronous result FIFO; full/empty from an extra pointer wrap bit.
// Push and pop in the same cycle are both honoured, including when full.
module adc_ctrl_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_valid,
  output logic             o_full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_empty;
  logic             w_wr_en;
  logic             w_rd_en;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd_en = i_pop && !w_empty;
  assign w_wr_en = i_push && (!o_full || w_rd_en);
  assign o_valid = !w_empty;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage; cleared so the head reads 0 out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '{default: '0};
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/adc_conv_ctrl.sv
// SAR ADC conversion initiator: launches start pulse trains, waits for the
// synchronized finish edge and queues results for the host.
// Optional feature macro: ADC_CTRL_TIMEOUT_EN (WAIT_DONE watchdog).
module adc_conv_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned START_HI    = 4,
  parameter int unsigned START_LO    = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        trigger,
  input  logic [15:0] period,
  input  logic [2:0]  cfg_osr,
  input  logic [4:0]  cfg_delay,
  input  logic [5:0]  cfg_delay_edge,
  output logic        start_conversion_out,
  output logic [15:0] config_1_out,
  output logic [15:0] config_2_out,
  input  logic        conversion_finished_in,
  input  logic [15:0] result_in,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        overflow,
  output logic        cfg_err,
  output logic        timeout,
  input  logic        clr
);

  localparam int unsigned RES_W  = 16;
  localparam int unsigned PER_W  = 16;
  localparam int unsigned PH_MAX = (START_HI > START_LO) ? START_HI : START_LO;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  state_t            r_state;
  logic              r_busy;
  logic              r_start;
  logic [CFG_W-1:0]  r_cfg1;
  logic [CFG_W-1:0]  r_cfg2;
  logic [PCNT_W-1:0] r_pcnt;
  logic [PCNT_W-1:0] r_ptarget;
  logic [PH_W-1:0]   r_ph;
  logic [PER_W-1:0]  r_period_cnt;
  logic              r_fin_meta;
  logic              r_fin_sync;
  logic              r_fin_prev;
  logic              r_overflow;
  logic              r_cfg_err;

  logic              w_fin_rise;
  logic              w_launch_req;
  logic              w_cfg_ok;
  logic              w_launch;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_rd_valid;
  logic [RES_W-1:0]  w_rd_data;

  assign w_fin_rise   = r_fin_sync & ~r_fin_prev;
  assign w_launch_req = (r_state == IDLE) && (trigger || (enable && (r_period_cnt >= period)));
  assign w_cfg_ok     = cfg_ok(cfg_osr, cfg_delay);
  assign w_launch     = w_launch_req && w_cfg_ok;
  assign w_push       = (r_state == CAPTURE);
  assign w_pop        = w_rd_valid && rd_ready;

  // 2-FF synchronizer plus a delayed copy for rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fin_meta <= 1'b0;
      r_fin_sync <= 1'b0;
      r_fin_prev <= 1'b0;
    end else begin
      r_fin_meta <= conversion_finished_in;
      r_fin_sync <= r_fin_meta;
      r_fin_prev <= r_fin_sync;
    end
  end

  // Saturating cycles-since-launch counter for continuous mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
    end else if (w_launch) begin
      r_period_cnt <= '0;
    end else if (r_period_cnt != '1) begin
      r_period_cnt <= r_period_cnt + PER_W'(1);
    end
  end

`ifdef ADC_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = 16;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;
  logic            w_to_hit;

  assign w_to_hit = (r_state == WAIT_DONE) && !w_fin_rise &&
                    (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign timeout  = r_timeout;

  // Watchdog counts cycles spent in WAIT_DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state != WAIT_DONE) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // Sticky watchdog flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout <= 1'b0;
    end else if (w_to_hit) begin
      r_timeout <= 1'b1;
    end else if (clr) begin
      r_timeout <= 1'b0;
    end
  end
`else
  logic w_unused_timeout_cyc;
  assign w_unused_timeout_cyc = (TIMEOUT_CYC == 0);
  assign timeout = 1'b0;
`endif

  // Sticky error flags; a new event wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      if (clr) begin
        r_overflow <= 1'b0;
        r_cfg_err  <= 1'b0;
      end
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_launch_req && !w_cfg_ok)  r_cfg_err  <= 1'b1;
    end
  end

  // Sequencer: pulse train, wait for finish, capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_start   <= 1'b0;
      r_cfg1    <= '0;
      r_cfg2    <= '0;
      r_pcnt    <= '0;
      r_ptarget <= '0;
      r_ph      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_cfg1    <= pack_cfg1(cfg_delay_edge, cfg_osr);
            r_cfg2    <= pack_cfg2(cfg_delay);
            r_ptarget <= osr_pulses(cfg_osr);
            r_pcnt    <= '0;
            r_ph      <= '0;
            r_start   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= START_H;
          end
        end
        START_H: begin
          if (r_ph == PH_W'(START_HI - 1)) begin
            r_ph    <= '0;
            r_start <= 1'b0;
            r_state <= START_L;
          end else begin
            r_ph <= r_ph + PH_W'(1);
          end
        end
        START_L: begin
          if (r_ph == PH_W'(START_LO - 1)) begin
            r_ph   <= '0;
            r_pcnt <= r_pcnt + PCNT_W'(1);
            if (r_pcnt + PCNT_W'(1) == r_ptarget) begin
              r_state <= WAIT_DONE;
            end else begin
              r_start <= 1'b1;
              r_state <= START_H;
            end
          end else begin
            r_ph <= r_ph + PH_W'(1);
          end
        end
        WAIT_DONE: begin
          if (w_fin_rise) begin
            r_state <= CAPTURE;
          end
`ifdef ADC_CTRL_TIMEOUT_EN
          else if (w_to_hit) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
`endif
        end
        CAPTURE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_start <= 1'b0;
        end
      endcase
    end
  end

  adc_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (result_in),
    .i_pop   (w_pop),
    .o_rdata (w_rd_data),
    .o_valid (w_rd_valid),
    .o_full  (w_full)
  );

  assign start_conversion_out = r_start;
  assign config_1_out         = r_cfg1;
  assign config_2_out         = r_cfg2;
  assign busy                 = r_busy;
  assign rd_data              = w_rd_data;
  assign rd_valid             = w_rd_valid;
  assign overflow             = r_overflow;
  assign cfg_err              = r_cfg_err;

endmodule
